buzzer_sequencer: RTL and testbench
===================================

Name: buzzer_sequencer

Overview:
- Downstream consumer of the game core's crash and 60-second level-pass indications.
- Converts those levels into short audible note sequences on the piezo buzzer pin, replacing the raw level-driven `beep`.
- Single clock domain (board CLK). Tone pitch and note timing are generated internally from CLK.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz; all note half-periods derive from it.
- NOTE_CYC, 6_250_000, tone duration of each note in CLK cycles (125 ms at default).
- GAP_CYC, 781_250, silent gap after each note in CLK cycles.
- CNT_W, 24, width of the internal tone and duration counters; must hold max(NOTE_CYC, GAP_CYC, CLK_HZ/880).

Ports:
- CLK  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- crash  in  1  level, high while bird collides with pipe; synchronous to CLK.
- win  in  1  level, high while 60 s pass state is held; synchronous to CLK.
- mute  in  1  forces beep low; sequencing continues.
- beep  out  1  registered square-wave buzzer drive.
- busy  out  1  high while any sequence (notes or gaps) is active.
- note_idx  out  2  index of current note within the active sequence; 0 when idle.

Behaviour:
- Reset: the following hold on the first CLK edge with rst_n=0, regardless of state.
  - beep=0, busy=0, note_idx=0, FSM=IDLE.
  - Edge-detect registers cleared to 0, so an input already high out of reset counts as a rising edge.
- Edge detect: crash_q/win_q are registered copies of the inputs. A rise is input=1 while the _q copy is 0 in the same cycle.
- Half-periods: HP = CLK_HZ/(2*f), integer division truncated.
  - Crash sequence: 880, 660, 440 Hz (3 notes).
  - Win sequence: 523, 659, 784, 1047 Hz (4 notes).
- FSM states: IDLE, TONE, GAP. A seq register (CRASH/WIN) records which sequence is playing.
  - IDLE -> TONE in the cycle after a rise. Load note_idx=0, duration counter=0, tone counter=0, busy=1.
  - TONE: beep=1 on the first TONE cycle and toggles every HP cycles. Exit to GAP after exactly NOTE_CYC cycles.
  - GAP: beep=0 for exactly GAP_CYC cycles.
    - Then, if more notes remain: note_idx+1 and back to TONE.
    - Otherwise: IDLE, busy=0, note_idx=0.
- Latency: rise sampled at edge t; beep=1 and busy=1 visible after edge t+1.
- Total length: crash = 3*(NOTE_CYC+GAP_CYC) cycles; win = 4*(NOTE_CYC+GAP_CYC) cycles.
- Priority and simultaneous events:
  - Crash and win rise in the same cycle: crash plays; the win rise is discarded.
  - Crash rise during WIN: abort and restart as CRASH note 0 next cycle.
  - Win rise during CRASH: ignored.
  - Rise of the currently playing sequence's own input: ignored (no restart).
  - Falling edges never affect playback.
- mute=1 forces beep=0 combinationally-free (registered, effective next edge). Counters, busy and note_idx are unaffected.
- Reset asserted mid-sequence: all state returns to reset values on that edge, and no sequence resumes after release.

Optional Feature:
- Macro: BUZZER_CRASH_LOOP_EN.
- Defined: after the final GAP of a CRASH sequence, if crash is still 1, the sequence restarts at note_idx=0 (TONE) with no extra idle cycle. busy stays 1 throughout. This repeats until crash is 0 at a sequence end.
- Undefined: CRASH plays exactly once per rise.
- WIN sequences never loop in either build.

Test Plan (CLK_HZ=100_000, NOTE_CYC=1000, GAP_CYC=100; crash HPs 56/75/113, win HPs 95/75/63/47):
- Reset: hold rst_n=0 for 5 cycles with crash=1 -> beep=0, busy=0, note_idx=0. After release, the crash rise is detected and beep=1 one cycle later.
- Crash: pulse crash 0->1 and hold -> beep toggles every 56 cycles for 1000 cycles, then 0 for 100 cycles, then HP 75, then HP 113. busy drops exactly 3300 cycles after entry, note_idx sequence 0,1,2 (loop macro undefined).
- Win: raise win -> 4 notes with HPs 95, 75, 63, 47; busy high for exactly 4400 cycles.
- Preemption:
  - Crash rise at cycle 1500 of WIN -> next cycle note_idx=0 and HP 56.
  - Win rise during CRASH -> no change.
  - Simultaneous rises -> crash plays.
- Mute: assert mute during note 1 of CRASH -> beep=0 while muted; busy and note_idx timing identical to the unmuted run.
- Loop build: BUZZER_CRASH_LOOP_EN defined, crash held for 8000 cycles -> sequence repeats with no idle gap. busy falls at the end of the 3rd sequence (9900 cycles); with crash low by then, no 4th pass.

Source files
------------

// File: rtl/buzzer_sequencer_if.sv
// Buzzer sequencer signal bundle: game-core event levels in, buzzer drive and status out.
// The game core drives the master side; the sequencer takes the slave side.
interface buzzer_sequencer_if;
   logic       crash;
   logic       win;
   logic       mute;
   logic       beep;
   logic       busy;
   logic [1:0] note_idx;

   modport master (output crash, win, mute, input beep, busy, note_idx);
   modport slave  (input crash, win, mute, output beep, busy, note_idx);
endinterface

// File: rtl/buzzer_sequencer.sv
// Plays short note sequences on the piezo pin when crash or win rises; crash preempts win.
// Build option BUZZER_CRASH_LOOP_EN: a crash sequence repeats while crash stays high at its end.
module buzzer_sequencer #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int NOTE_CYC = 6_250_000,
   parameter int GAP_CYC  = 781_250,
   parameter int CNT_W    = 24
) (
   input  logic               CLK,
   input  logic               rst_n,
   buzzer_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;
   typedef enum logic {SEQ_CRASH, SEQ_WIN} seq_t;

   localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
   // Slots 0-2 crash notes, 3-6 win notes; slot 7 is a spare that keeps the 3-bit index in range.
   localparam int FREQ [0:7] = '{880, 660, 440, 523, 659, 784, 1047, 1047};

   logic [CNT_W-1:0] hp_tab [0:7];

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_hp
         assign hp_tab[gi] = CNT_W'(CLK_HZ / (2 * FREQ[gi]));
      end
   endgenerate

   state_t           state_reg, state_next;
   seq_t             seq_reg, seq_next;
   logic [1:0]       note_idx_reg, note_idx_next;
   logic [CNT_W-1:0] dur_reg, dur_next;
   logic [CNT_W-1:0] tone_reg, tone_next;
   logic             phase_reg, phase_next;
   logic             beep_reg, beep_next;
   logic             crash_q, win_q;
   logic             crash_rise_reg, win_rise_reg;

   logic             busy_int, start_crash, start_win, loop_restart, restart;
   logic             last_note, tone_end, gap_end, half_end;
   logic [2:0]       hp_idx;
   logic [CNT_W-1:0] hp_last;

   assign busy_int    = (state_reg != IDLE);
   assign start_crash = crash_rise_reg && !(busy_int && seq_reg == SEQ_CRASH);
   assign start_win   = win_rise_reg && !busy_int && !crash_rise_reg;
   assign last_note   = (note_idx_reg == ((seq_reg == SEQ_CRASH) ? 2'd2 : 2'd3));
   assign tone_end    = (state_reg == TONE) && (dur_reg == NOTE_LAST);
   assign gap_end     = (state_reg == GAP) && (dur_reg == GAP_LAST);
   assign hp_idx      = (seq_reg == SEQ_WIN) ? (3'd3 + {1'b0, note_idx_reg}) : {1'b0, note_idx_reg};
   assign hp_last     = hp_tab[hp_idx] - CNT_W'(1);
   assign half_end    = (tone_reg == hp_last);

`ifdef BUZZER_CRASH_LOOP_EN
   assign loop_restart = gap_end && last_note && (seq_reg == SEQ_CRASH) && bus.crash;
`else
   assign loop_restart = 1'b0;
`endif

   assign restart = start_crash || start_win || loop_restart;

   // State register; rises are registered so playback starts the cycle after detection.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         seq_reg        <= SEQ_CRASH;
         note_idx_reg   <= 2'd0;
         dur_reg        <= '0;
         tone_reg       <= '0;
         phase_reg      <= 1'b0;
         beep_reg       <= 1'b0;
         crash_q        <= 1'b0;
         win_q          <= 1'b0;
         crash_rise_reg <= 1'b0;
         win_rise_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         seq_reg        <= seq_next;
         note_idx_reg   <= note_idx_next;
         dur_reg        <= dur_next;
         tone_reg       <= tone_next;
         phase_reg      <= phase_next;
         beep_reg       <= beep_next;
         crash_q        <= bus.crash;
         win_q          <= bus.win;
         crash_rise_reg <= bus.crash && !crash_q;
         win_rise_reg   <= bus.win && !win_q;
      end
   end

   always_comb begin
      state_next = state_reg;
      seq_next   = seq_reg;
      if (start_crash) begin
         state_next = TONE;
         seq_next   = SEQ_CRASH;
      end else if (start_win) begin
         state_next = TONE;
         seq_next   = SEQ_WIN;
      end else if (loop_restart) begin
         state_next = TONE;
      end else begin
         case (state_reg)
            TONE:    if (tone_end) state_next = GAP;
            GAP:     if (gap_end) state_next = last_note ? IDLE : TONE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Phase keeps running under mute so unmuting resumes mid-note in step.
   always_comb begin
      note_idx_next = note_idx_reg;
      dur_next      = dur_reg + CNT_W'(1);
      tone_next     = tone_reg;
      phase_next    = phase_reg;
      if (restart) begin
         note_idx_next = 2'd0;
         dur_next      = '0;
         tone_next     = '0;
         phase_next    = 1'b1;
      end else begin
         case (state_reg)
            TONE: begin
               if (tone_end) begin
                  dur_next   = '0;
                  tone_next  = '0;
                  phase_next = 1'b0;
               end else if (half_end) begin
                  tone_next  = '0;
                  phase_next = !phase_reg;
               end else begin
                  tone_next  = tone_reg + CNT_W'(1);
               end
            end
            GAP: begin
               if (gap_end) begin
                  dur_next = '0;
                  if (last_note) begin
                     note_idx_next = 2'd0;
                  end else begin
                     note_idx_next = note_idx_reg + 2'd1;
                     phase_next    = 1'b1;
                  end
               end
            end
            default: begin
               note_idx_next = 2'd0;
               dur_next      = '0;
               tone_next     = '0;
               phase_next    = 1'b0;
            end
         endcase
      end
      beep_next = (state_next == TONE) && phase_next && !bus.mute;
   end

   assign bus.beep     = beep_reg;
   assign bus.busy     = busy_int;
   assign bus.note_idx = note_idx_reg;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer at a scaled-down clock (100 kHz, 1000/100-cycle notes/gaps).
// Define BUZZER_CRASH_LOOP_EN for both RTL and bench to exercise the looping crash build.
module tb_buzzer_sequencer;

   localparam int CLK_HZ   = 100_000;
   localparam int NOTE_CYC = 1000;
   localparam int GAP_CYC  = 100;
   localparam int SEQ_LEN  = NOTE_CYC + GAP_CYC;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   buzzer_sequencer_if bif ();

   buzzer_sequencer #(
      .CLK_HZ   (CLK_HZ),
      .NOTE_CYC (NOTE_CYC),
      .GAP_CYC  (GAP_CYC),
      .CNT_W    (24)
   ) dut (
      .CLK   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hand-computed half-periods for 100 kHz.
   function automatic int hp_of(input bit is_crash, input int n);
      int c [0:2];
      int w [0:3];
      c = '{56, 75, 113};
      w = '{95, 75, 63, 47};
      return is_crash ? c[n] : w[n];
   endfunction

   function automatic logic model_beep(input bit is_crash, input int k);
      int off;
      int n;
      off = k % SEQ_LEN;
      n   = k / SEQ_LEN;
      if (off >= NOTE_CYC) return 1'b0;
      return ((off / hp_of(is_crash, n)) % 2) == 0;
   endfunction

   // Walks ncyc cycles from sequence cycle 0, applying scheduled input events and tallying
   // cycles whose outputs differ from the model; callers judge the tally.
   task automatic scan(input bit is_crash, input int ncyc, input int period,
                       input int m_on, input int m_off, input int crash_off_k, input int win_on_k,
                       output int bad, output int first_k);
      logic exp_b;
      int   kk;
      bad = 0;
      first_k = -1;
      for (int k = 0; k < ncyc; k++) begin
         kk = k % period;
         exp_b = (k > m_on && k <= m_off) ? 1'b0 : model_beep(is_crash, kk);
         if (bif.beep !== exp_b || bif.busy !== 1'b1 || bif.note_idx !== 2'(kk / SEQ_LEN)) begin
            if (bad == 0) first_k = k;
            bad++;
         end
         bif.mute = (k >= m_on && k < m_off);
         if (k == crash_off_k) bif.crash = 1'b0;
         if (k == win_on_k) bif.win = 1'b1;
         step();
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (bif.busy !== 1'b0 || bif.beep !== 1'b0 || bif.note_idx !== 2'd0) begin
         failures++;
         $display("FAIL %s busy=%b beep=%b note_idx=%0d required 0/0/0", name, bif.busy, bif.beep, bif.note_idx);
      end
   endtask

   task automatic check_wave(input string name, input int bad, input int first_k);
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL %s bad_cycles=%0d required=0 first_bad_cycle=%0d", name, bad, first_k);
      end
   endtask

   task automatic start_seq();
      step();
      step();
   endtask

   task automatic test_reset();
      int n;
      bif.crash = 1'b1;
      rst_n = 1'b0;
      repeat (5) step();
      check_idle("reset_hold");
      rst_n = 1'b1;
      step();
      checks++;
      if (bif.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_detect_cycle busy=%b required 0", bif.busy);
      end
      step();
      checks++;
      if (bif.beep !== 1'b1 || bif.busy !== 1'b1 || bif.note_idx !== 2'd0) begin
         failures++;
         $display("FAIL reset_rise_latency beep=%b busy=%b note_idx=%0d required 1/1/0", bif.beep, bif.busy, bif.note_idx);
      end
      bif.crash = 1'b0;
      n = 0;
      while (bif.busy === 1'b1 && n < 4000) begin
         step();
         n++;
      end
      checks++;
      if (n !== 3300) begin
         failures++;
         $display("FAIL reset_first_seq_len cycles=%0d required=3300", n);
      end
      step();
   endtask

   task automatic test_crash();
      int bad, fk;
      bif.crash = 1'b1;
      start_seq();
`ifdef BUZZER_CRASH_LOOP_EN
      scan(1'b1, 9900, 3300, -1, -1, 8000, -1, bad, fk);
      check_wave("crash_loop_wave", bad, fk);
`else
      scan(1'b1, 3300, 3300, -1, -1, -1, -1, bad, fk);
      check_wave("crash_wave", bad, fk);
`endif
      check_idle("crash_end");
      repeat (20) step();
      check_idle("crash_no_restart");
      bif.crash = 1'b0;
      step();
   endtask

   task automatic test_win();
      int bad, fk;
      bif.win = 1'b1;
      start_seq();
      scan(1'b0, 4400, 4400, -1, -1, -1, -1, bad, fk);
      check_wave("win_wave", bad, fk);
      check_idle("win_end");
      bif.win = 1'b0;
      step();
   endtask

   task automatic test_preempt();
      int bad, fk;
      bif.win = 1'b1;
      start_seq();
      scan(1'b0, 1500, 4400, -1, -1, -1, -1, bad, fk);
      check_wave("preempt_win_part", bad, fk);
      bif.crash = 1'b1;
      step();
      checks++;
      if (bif.note_idx !== 2'd1 || bif.busy !== 1'b1) begin
         failures++;
         $display("FAIL preempt_detect_cycle note_idx=%0d busy=%b required 1/1", bif.note_idx, bif.busy);
      end
      step();
      checks++;
      if (bif.note_idx !== 2'd0 || bif.beep !== 1'b1) begin
         failures++;
         $display("FAIL preempt_restart note_idx=%0d beep=%b required 0/1", bif.note_idx, bif.beep);
      end
      scan(1'b1, 3300, 3300, -1, -1, 50, -1, bad, fk);
      check_wave("preempt_crash_wave", bad, fk);
      check_idle("preempt_end");
      bif.win = 1'b0;
      step();
   endtask

   task automatic test_win_during_crash();
      int bad, fk;
      bif.crash = 1'b1;
      start_seq();
      scan(1'b1, 3300, 3300, -1, -1, 100, 500, bad, fk);
      check_wave("win_during_crash_wave", bad, fk);
      check_idle("win_during_crash_end");
      repeat (20) step();
      check_idle("win_discarded");
      bif.win = 1'b0;
      step();
   endtask

   task automatic test_simultaneous();
      int bad, fk;
      bif.crash = 1'b1;
      bif.win = 1'b1;
      start_seq();
      scan(1'b1, 3300, 3300, -1, -1, 100, -1, bad, fk);
      check_wave("simultaneous_wave", bad, fk);
      check_idle("simultaneous_end");
      bif.win = 1'b0;
      step();
   endtask

   task automatic test_mute();
      int bad, fk;
      bif.crash = 1'b1;
      start_seq();
      scan(1'b1, 3300, 3300, 1200, 1800, 100, -1, bad, fk);
      check_wave("mute_wave", bad, fk);
      check_idle("mute_end");
      step();
   endtask

   task automatic test_reset_mid();
      int bad, fk;
      bif.crash = 1'b1;
      start_seq();
      scan(1'b1, 700, 3300, -1, -1, 100, -1, bad, fk);
      check_wave("reset_mid_wave", bad, fk);
      rst_n = 1'b0;
      step();
      check_idle("reset_mid_clear");
      rst_n = 1'b1;
      repeat (20) step();
      check_idle("reset_mid_no_resume");
   endtask

   initial begin
      bif.crash = 1'b0;
      bif.win = 1'b0;
      bif.mute = 1'b0;
      test_reset();
      test_crash();
      test_win();
      test_preempt();
      test_win_during_crash();
      test_simultaneous();
      test_mute();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
